secret_code_gen: RTL and testbench

- Consumes the 1-bit-per-clock pseudo-random stream from the LFSR RNG stage and assembles a secret code for the codebreaking game.
- The code is NUM_DIGITS digits, each in the range 0..DIGIT_MAX. Optionally, no digit may repeat.
- Uses rejection sampling: out-of-range or duplicate candidates are discarded and re-drawn.
- Sits between the RNG and the game controller; the controller requests a code and latches it when valid.

---
 rtl/secret_code_gen_if.sv | 37 +++
 rtl/secret_code_gen.sv | 123 ++++++++++++
 tb/tb_secret_code_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/secret_code_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : secret_code_gen_if
// Description : Request/result bundle between the RNG/controller side and
//               the secret code generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface secret_code_gen_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                          rng_in;
    logic                          gen_start;
    logic                          busy;
    logic                          code_valid;
    logic [NUM_DIGITS*DIGIT_W-1:0] code_out;
    logic [7:0]                    attempts;

    modport master (
        output rng_in,
        output gen_start,
        input  busy,
        input  code_valid,
        input  code_out,
        input  attempts
    );

    modport slave (
        input  rng_in,
        input  gen_start,
        output busy,
        output code_valid,
        output code_out,
        output attempts
    );
endinterface
`default_nettype wire

// File: rtl/secret_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : secret_code_gen
// Description : Assembles a game secret code from a serial random stream by
//               rejection sampling (out-of-range and optional duplicate reject).
// Revision    : 1.0 - initial release
// ============================================================================
module secret_code_gen #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int UNIQUE     = 1
) (
    input  wire              clk,
    input  wire              rst,
    secret_code_gen_if.slave bus
);
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int BIT_W  = $clog2(DIGIT_W + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
    localparam logic [DIGIT_W-1:0] c_DIGIT_MAX = DIGIT_W'(DIGIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]   r_digit_idx;
    logic [DIGIT_W-1:0] r_cand;
    logic [CODE_W-1:0]  r_code;
    logic [7:0]         r_attempts;

    logic w_start;
    logic w_last_bit;
    logic w_last_digit;
    logic w_dup;
    logic w_accept;

    assign w_start      = bus.gen_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_bit   = (r_bit_cnt == BIT_W'(DIGIT_W - 1));
    assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

    // Only slots already filled take part, so an empty (zero) slot never
    // rejects a legitimate zero candidate.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) < r_digit_idx) &&
                (r_code[(NUM_DIGITS-i)*DIGIT_W-1 -: DIGIT_W] == r_cand)) begin
                w_dup = 1'b1;
            end
        end
    end

    assign w_accept = (r_cand <= c_DIGIT_MAX) && !((UNIQUE != 0) && w_dup);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.gen_start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_last_bit)    w_state_nxt = S_CHECK;
            S_CHECK:   w_state_nxt = (w_accept && w_last_digit) ? S_DONE : S_COLLECT;
            S_DONE:    if (bus.gen_start) w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_digit_idx <= '0;
            r_cand      <= '0;
            r_code      <= '0;
            r_attempts  <= '0;
        end else if (w_start) begin
            r_bit_cnt   <= '0;
            r_digit_idx <= '0;
            r_cand      <= '0;
            r_code      <= '0;
            r_attempts  <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_cand    <= {r_cand[DIGIT_W-2:0], bus.rng_in};
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BIT_W'(1);
                end
                S_CHECK: begin
                    if (r_attempts != 8'hFF) begin
                        r_attempts <= r_attempts + 8'd1;
                    end
                    if (w_accept) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (IDX_W'(i) == r_digit_idx) begin
                                r_code[(NUM_DIGITS-i)*DIGIT_W-1 -: DIGIT_W] <= r_cand;
                            end
                        end
                        r_digit_idx <= r_digit_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state == S_COLLECT) || (r_state == S_CHECK);
    assign bus.code_valid = (r_state == S_DONE);
    assign bus.code_out   = r_code;
    assign bus.attempts   = r_attempts;
endmodule
`default_nettype wire

// File: tb/tb_secret_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_secret_code_gen
// Description : Self-checking bench; UNIQUE=1 and UNIQUE=0 instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secret_code_gen;
    localparam int ND      = 4;
    localparam int DW      = 4;
    localparam int DM      = 9;
    localparam int CW      = ND * DW;
    localparam int NSTREAM = 400;

    logic clk = 1'b0;
    logic rst;
    logic gen_start;
    logic rng_in;

    always #5 clk = ~clk;

    secret_code_gen_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) bu ();
    secret_code_gen_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) bn ();

    assign bu.rng_in    = rng_in;
    assign bu.gen_start = gen_start;
    assign bn.rng_in    = rng_in;
    assign bn.gen_start = gen_start;

    secret_code_gen #(.NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_MAX(DM), .UNIQUE(1)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bu.slave)
    );

    secret_code_gen #(.NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_MAX(DM), .UNIQUE(0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bn.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    logic stream[$];   // rng_in value for edge j after the start edge is stream[j-1]

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Candidates occupy consecutive blocks of DW+1 cycles: DW sampled bits then
    // one ignored evaluation cycle.
    task automatic model(input bit uniq, output logic [CW-1:0] code,
                         output int att, output int cyc);
        int digits[$];
        int blk;
        blk  = 0;
        code = '0;
        cyc  = -1;
        while (digits.size() < ND && (blk + 1) * (DW + 1) <= stream.size()) begin
            int  v;
            bit  dup;
            v   = 0;
            dup = 0;
            for (int b = 0; b < DW; b++) v = v * 2 + int'(stream[blk*(DW+1)+b]);
            blk++;
            foreach (digits[k]) if (digits[k] == v) dup = 1;
            if (v <= DM && !(uniq && dup)) digits.push_back(v);
        end
        att = (blk > 255) ? 255 : blk;
        if (digits.size() == ND) cyc = blk * (DW + 1);
        foreach (digits[k]) code = {code[CW-DW-1:0], DW'(digits[k])};
    endtask

    task automatic push_cand(input int v);
        for (int b = DW - 1; b >= 0; b--) stream.push_back(v[b]);
        stream.push_back(1'($urandom));
    endtask

    task automatic chk_dut(input string tag, input logic busy, input logic valid,
                           input logic [CW-1:0] code, input logic [7:0] att,
                           input int j, input int e, input logic [CW-1:0] c, input int a);
        chk({tag, " code_valid"}, 32'(valid), 32'(j >= e));
        chk({tag, " busy"}, 32'(busy), 32'(j < e));
        chk({tag, " attempts"}, 32'(att), 32'((j >= e) ? a : j / (DW + 1)));
        if (j >= e) chk({tag, " code_out"}, 32'(code), 32'(c));
        if (j == 1) chk({tag, " code_out cleared"}, 32'(code), 32'd0);
    endtask

    task automatic run(input string name, input int pulse_at, input int rst_at,
                       input bit use_lit, input logic [CW-1:0] lit_u, input logic [CW-1:0] lit_n);
        logic [CW-1:0] cu, cn;
        int au, an, eu, en, last;
        while (stream.size() < NSTREAM) stream.push_back(1'($urandom));
        model(1'b1, cu, au, eu);
        model(1'b0, cn, an, en);
        last = ((eu > en) ? eu : en) + 2;
        if (rst_at > 0) last = rst_at;
        @(negedge clk);
        gen_start = 1'b1;
        rng_in    = 1'($urandom);
        @(negedge clk);
        for (int j = 0; j <= last; j++) begin
            if (j > 0) begin
                if (rst_at > 0 && j == rst_at) begin
                    chk({name, " rst busy_u"}, 32'(bu.busy), 32'd0);
                    chk({name, " rst valid_u"}, 32'(bu.code_valid), 32'd0);
                    chk({name, " rst code_u"}, 32'(bu.code_out), 32'd0);
                    chk({name, " rst att_u"}, 32'(bu.attempts), 32'd0);
                    chk({name, " rst busy_n"}, 32'(bn.busy), 32'd0);
                    chk({name, " rst code_n"}, 32'(bn.code_out), 32'd0);
                    chk({name, " rst att_n"}, 32'(bn.attempts), 32'd0);
                    rst = 1'b0;
                end else begin
                    chk_dut({name, " u"}, bu.busy, bu.code_valid, bu.code_out, bu.attempts, j, eu, cu, au);
                    chk_dut({name, " n"}, bn.busy, bn.code_valid, bn.code_out, bn.attempts, j, en, cn, an);
                end
            end
            if (j == last) break;
            gen_start = (j + 1 == pulse_at);
            rst       = (j + 1 == rst_at);
            rng_in    = stream[j];
            @(negedge clk);
        end
        if (use_lit) begin
            chk({name, " literal code_u"}, 32'(bu.code_out), 32'(lit_u));
            chk({name, " literal code_n"}, 32'(bn.code_out), 32'(lit_n));
        end
        gen_start = 1'b0;
        stream.delete();
    endtask

    initial begin
        rst       = 1'b1;
        gen_start = 1'b0;
        rng_in    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bu.busy), 32'd0);
        chk("reset valid", 32'(bu.code_valid), 32'd0);
        chk("reset code", 32'(bu.code_out), 32'd0);
        chk("reset attempts", 32'(bu.attempts), 32'd0);
        chk("reset valid_n", 32'(bn.code_valid), 32'd0);
        rst = 1'b0;

        push_cand(3); push_cand(7); push_cand(1); push_cand(8);
        run("basic", 0, 0, 1'b1, 16'h3718, 16'h3718);

        push_cand(15); push_cand(2); push_cand(4); push_cand(6); push_cand(0);
        run("range", 0, 0, 1'b1, 16'h2460, 16'h2460);

        push_cand(5); push_cand(5); push_cand(1); push_cand(2); push_cand(3);
        run("dup", 0, 0, 1'b1, 16'h5123, 16'h5512);

        push_cand(3); push_cand(7); push_cand(1); push_cand(8);
        run("midstart", 7, 0, 1'b1, 16'h3718, 16'h3718);

        run("midrst", 0, 10, 1'b0, '0, '0);
        run("after_rst", 0, 0, 1'b0, '0, '0);

        for (int r = 0; r < 8; r++) run("rand", 0, 0, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
